dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the target end of the pipeline's load/store port.
//  Takes one request at a time from the memory stage on a valid/ready handshake.
//  Performs a byte, halfword or word access to internal RAM, or a read of the ioin register.
//  Returns a one-cycle response after a programmable number of wait states.
//  Lets the core's stall/forwarding logic be exercised against a non-zero-latency memory.
// PARAMETERS
//  ADDR_WIDTH  16            byte-address bits of RAM; RAM spans 0 .. 2**ADDR_WIDTH-1
//  LATENCY     2             wait states between acceptance and access, 0..15
//  IO_ADDR     32'h0001_0000 word address of the read-only ioin register
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   reset, asynchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept a request this cycle
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  req_we     in   1   1 = store, 0 = load
//  req_width  in   3   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ioin       in   32  external input, read at IO_ADDR
//  rsp_valid  out  1   response pulse, exactly one cycle per accepted request
//  rsp_rdata  out  32  load data, extended per req_width; 0 for stores and errors
//  rsp_err    out  1   request rejected; no state change
// BEHAVIOUR
//  Reset:
//   - FSM to IDLE; wait counter 0; rsp_valid, rsp_rdata, rsp_err all 0.
//   - req_ready is 0 while rst is high. RAM contents are not reset.
//  FSM states: IDLE, WAIT, RESP.
//   - IDLE: req_ready=1.
//     - On req_valid & req_ready, latch addr/wdata/we/width and load counter with LATENCY.
//     - Then go to WAIT.
//   - WAIT: req_ready=0.
//     - Counter != 0: decrement.
//     - Counter == 0: perform the access, register the result, go to RESP.
//   - RESP: rsp_valid=1 and req_ready=0 for this one cycle, then IDLE.
//  Latency:
//   - rsp_valid is high exactly LATENCY+1 cycles after the accepting edge.
//   - Back-to-back: with req_valid held high, the next acceptance is on the first cycle after RESP.
//     Throughput is 1 request per LATENCY+3 cycles.
//  No response backpressure: the requester must take rsp_* in the RESP cycle.
//  Inputs are ignored outside IDLE.
//  Byte order and extension:
//   - RAM is little-endian bytes.
//   - B and H loads sign-extend; BU and HU loads zero-extend.
//   - Stores write only the addressed byte or bytes.
//  Errors: rsp_err=1, rsp_rdata=0, no RAM write, when any of the following holds:
//   - H/HU with addr[0]=1, or W with addr[1:0]!=0;
//   - width is 011, 110 or 111, or a store uses 100/101;
//   - addr >= 2**ADDR_WIDTH and addr != IO_ADDR;
//   - access at IO_ADDR is a store, or is not width W.
//  IO: LW at IO_ADDR returns ioin as sampled on the access edge (WAIT->RESP).
//  Store commit: RAM is written on the WAIT->RESP edge only.
//  Reset mid-operation:
//   - A request not yet past the access edge is dropped: no write, no rsp_valid.
//   - A reset during RESP clears rsp_valid immediately (asynchronous).
// TESTING
//  1. LATENCY=2, SW 0xDEADBEEF @0x100 accepted at cycle 0.
//     -> rsp_valid=1 only in cycle 3, err=0. Then LW @0x100 -> rdata 0xDEADBEEF.
//  2. After (1): LB 0x100 -> 0xFFFFFFEF; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD;
//     LHU 0x100 -> 0x0000BEEF.
//  3. SB wdata 0x00000055 @0x101, then LW @0x100 -> 0xDEAD55EF.
//     Then SH 0xA5A5 @0x102 and LW @0x100 -> 0xA5A555EF.
//  4. Errors:
//     - LH @0x101 -> err=1, rdata=0.
//     - SW @0x102 -> err=1, and a following LW @0x100 is unchanged.
//     - LW @0x0002_0000 -> err=1.
//  5. ioin=0x12345678, LW @IO_ADDR -> 0x12345678.
//     SW @IO_ADDR -> err=1. LB @IO_ADDR -> err=1.
//  6. Reset and back-to-back:
//     - Assert rst for 1 cycle while a SW 0x11111111 @0x200 is in WAIT.
//       -> no rsp_valid, req_ready=0 during rst and 1 on the first cycle after release.
//       -> a following LW @0x200 returns the old value.
//     - Hold req_valid high with LATENCY=0 -> accepts spaced exactly 3 cycles apart.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store port between the memory stage (master) and the data-memory responder (slave).
// Handshake: a request transfers on a rising edge where req_valid && req_ready; rsp_* is valid only while rsp_valid is high, for exactly one cycle, with no backpressure.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [2:0]  req_width;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_width,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_width,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states, byte/half/word RAM
// access plus a read-only ioin register, and a single-cycle response pulse.
module dmem_responder #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] IO_ADDR    = 32'h0001_0000
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    input  logic [31:0]      ioin,
    output logic [1:0]       dbgState
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} stateE;

    localparam logic [3:0] LAT = 4'(LATENCY);

    stateE       state, nextState;
    logic [3:0]  cnt;
    logic [31:0] aAddr, aWdata;
    logic        aWe;
    logic [2:0]  aWidth;
    logic [31:0] rspRdata;
    logic        rspErr;
    logic        accept, access, ready;

    logic [7:0]  mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        access    = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = !rst;
                if (bus.req_valid && !rst) begin
                    accept    = 1'b1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    access    = 1'b1;
                    nextState = RESP;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request decode, evaluated on the latched request during WAIT.
    logic                  isIo, outRange, badWidth, misalign, ioBad, err;
    logic [ADDR_WIDTH-1:0] idx;
    logic [7:0]            b0, b1, b2, b3;
    logic [31:0]           loadData, result;
    logic [3:0]            laneEn;

    always_comb begin
        isIo     = (aAddr == IO_ADDR);
        outRange = (aAddr >> ADDR_WIDTH) != 32'd0;
        badWidth = (aWidth == 3'b011) || (aWidth[2:1] == 2'b11) || (aWe && aWidth[2]);
        misalign = (aWidth[1:0] == 2'b01 && aAddr[0]) ||
                   (aWidth[1:0] == 2'b10 && aAddr[1:0] != 2'b00);
        ioBad    = isIo && (aWe || aWidth != 3'b010);
        err      = badWidth || misalign || (!isIo && outRange) || ioBad;

        idx = aAddr[ADDR_WIDTH-1:0];
        b0  = mem[idx];
        b1  = mem[idx + ADDR_WIDTH'(1)];
        b2  = mem[idx + ADDR_WIDTH'(2)];
        b3  = mem[idx + ADDR_WIDTH'(3)];

        // aWidth[2] selects the unsigned variants.
        case (aWidth[1:0])
            2'b00:   loadData = {{24{b0[7] & ~aWidth[2]}}, b0};
            2'b01:   loadData = {{16{b1[7] & ~aWidth[2]}}, b1, b0};
            default: loadData = {b3, b2, b1, b0};
        endcase

        if (err)       result = 32'd0;
        else if (isIo) result = ioin;
        else if (aWe)  result = 32'd0;
        else           result = loadData;

        laneEn = 4'b0000;
        if (access && !err && aWe && !isIo) begin
            case (aWidth[1:0])
                2'b00:   laneEn = 4'b0001;
                2'b01:   laneEn = 4'b0011;
                default: laneEn = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (laneEn[i]) mem[idx + ADDR_WIDTH'(i)] <= aWdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 4'd0;
            aAddr    <= 32'd0;
            aWdata   <= 32'd0;
            aWe      <= 1'b0;
            aWidth   <= 3'd0;
            rspRdata <= 32'd0;
            rspErr   <= 1'b0;
        end else begin
            if (accept) begin
                aAddr  <= bus.req_addr;
                aWdata <= bus.req_wdata;
                aWe    <= bus.req_we;
                aWidth <= bus.req_width;
                cnt    <= LAT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (access) begin
                rspRdata <= result;
                rspErr   <= err;
            end else if (state == RESP) begin
                rspRdata <= 32'd0;
                rspErr   <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rspRdata;
    assign bus.rsp_err   = rspErr;
    assign dbgState      = state;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus randomized traffic against a byte-level
// reference model; a second LATENCY=0 instance covers back-to-back acceptance.
module tb_dmem_responder;
  localparam logic [31:0] IO_ADDR = 32'h0001_0000;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] ioin = 32'd0;
  logic [1:0] dbgState, dbgState0;

  dmem_responder_if bus();
  dmem_responder_if bus0();

  dmem_responder #(.ADDR_WIDTH(16), .LATENCY(LAT), .IO_ADDR(IO_ADDR)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .ioin(ioin), .dbgState(dbgState)
  );

  dmem_responder #(.ADDR_WIDTH(16), .LATENCY(0), .IO_ADDR(IO_ADDR)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .ioin(ioin), .dbgState(dbgState0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [32:0] expQ[$];
  logic [7:0] refMem[int unsigned];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: access size, legality and extension computed with plain arithmetic.
  function automatic void refAccess(input logic [31:0] a, input logic [31:0] w, input logic we,
                                    input logic [2:0] wd, input logic [31:0] io,
                                    output logic [31:0] rd, output logic err);
    int unsigned size;
    bit legal, isSigned;
    longint v;
    size = (wd == 3'd0 || wd == 3'd4) ? 1 : (wd == 3'd1 || wd == 3'd5) ? 2 : 4;
    legal = (wd inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(we && wd >= 3'd4);
    isSigned = (wd < 3'd4);
    err = !legal || (a % size) != 0 ||
          ((a == IO_ADDR) ? (we || wd != 3'd2) : (a >= 32'h0001_0000));
    rd = 32'd0;
    if (!err) begin
      if (a == IO_ADDR) rd = io;
      else if (we) begin
        for (int i = 0; i < int'(size); i++) refMem[a + i] = 8'(w >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < int'(size); i++) v += longint'(refMem[a + i]) << (8 * i);
        if (isSigned && size < 4 && v >= (64'sd1 <<< (8 * size - 1))) v -= (64'sd1 <<< (8 * size));
        rd = 32'(v);
      end
    end
  endfunction

  // One request on the LATENCY=2 instance; checks latency, pulse width and payload.
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] w, input logic we,
                    input logic [2:0] wd, output logic [31:0] gotRd, output logic gotErr);
    logic [31:0] er;
    logic ee;
    logic [32:0] e;
    int n;
    refAccess(a, w, we, wd, ioin, er, ee);
    expQ.push_back({ee, er});
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_wdata = w; bus.req_we = we; bus.req_width = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 30) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 32'(n), 32'(LAT + 1));
    e = expQ.pop_front();
    chk({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e[32]});
    chk({tag, "_rdata"}, bus.rsp_rdata, e[31:0]);
    gotRd = bus.rsp_rdata;
    gotErr = bus.rsp_err;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  logic [31:0] rd;
  logic er;

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_we = 1'b0; bus.req_width = '0;
    bus0.req_valid = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.req_we = 1'b0; bus0.req_width = '0;

    // Clock/reset
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_state", {30'd0, dbgState}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);

    // Directed word/byte/half traffic
    op("sw100", 32'h100, 32'hDEADBEEF, 1'b1, 3'd2, rd, er);
    chk("sw100_k", {31'd0, er}, 32'd0);
    op("lw100", 32'h100, 32'd0, 1'b0, 3'd2, rd, er);   chk("lw100_k", rd, 32'hDEADBEEF);
    op("lb100", 32'h100, 32'd0, 1'b0, 3'd0, rd, er);   chk("lb100_k", rd, 32'hFFFFFFEF);
    op("lbu103", 32'h103, 32'd0, 1'b0, 3'd4, rd, er);  chk("lbu103_k", rd, 32'h000000DE);
    op("lh102", 32'h102, 32'd0, 1'b0, 3'd1, rd, er);   chk("lh102_k", rd, 32'hFFFFDEAD);
    op("lhu100", 32'h100, 32'd0, 1'b0, 3'd5, rd, er);  chk("lhu100_k", rd, 32'h0000BEEF);
    op("sb101", 32'h101, 32'h00000055, 1'b1, 3'd0, rd, er);
    op("lw_sb", 32'h100, 32'd0, 1'b0, 3'd2, rd, er);   chk("lw_sb_k", rd, 32'hDEAD55EF);
    op("sh102", 32'h102, 32'h0000A5A5, 1'b1, 3'd1, rd, er);
    op("lw_sh", 32'h100, 32'd0, 1'b0, 3'd2, rd, er);   chk("lw_sh_k", rd, 32'hA5A555EF);

    // Errors
    op("lh101", 32'h101, 32'd0, 1'b0, 3'd1, rd, er);   chk("lh101_k", {31'd0, er}, 32'd1);
    op("sw102", 32'h102, 32'hFFFFFFFF, 1'b1, 3'd2, rd, er); chk("sw102_k", {31'd0, er}, 32'd1);
    op("lw_keep", 32'h100, 32'd0, 1'b0, 3'd2, rd, er); chk("lw_keep_k", rd, 32'hA5A555EF);
    op("lw_oor", 32'h0002_0000, 32'd0, 1'b0, 3'd2, rd, er); chk("lw_oor_k", {31'd0, er}, 32'd1);

    // IO register
    ioin = 32'h12345678;
    op("lw_io", IO_ADDR, 32'd0, 1'b0, 3'd2, rd, er);   chk("lw_io_k", rd, 32'h12345678);
    op("sw_io", IO_ADDR, 32'h1, 1'b1, 3'd2, rd, er);   chk("sw_io_k", {31'd0, er}, 32'd1);
    op("lb_io", IO_ADDR, 32'd0, 1'b0, 3'd0, rd, er);   chk("lb_io_k", {31'd0, er}, 32'd1);

    // Reset while a store waits
    op("sw200", 32'h200, 32'hCAFEF00D, 1'b1, 3'd2, rd, er);
    bus.req_valid = 1'b1; bus.req_addr = 32'h200; bus.req_wdata = 32'h11111111;
    bus.req_we = 1'b1; bus.req_width = 3'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid_state", {30'd0, dbgState}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    chk("mid_rst_ready2", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", {31'd0, bus.req_ready}, 32'd1);
    begin
      int pulses = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus.rsp_valid) pulses++;
      end
      chk("mid_no_rsp", 32'(pulses), 32'd0);
    end
    op("lw200", 32'h200, 32'd0, 1'b0, 3'd2, rd, er);   chk("lw200_k", rd, 32'hCAFEF00D);

    // Randomized traffic over a pre-written window
    for (int i = 0; i < 16; i++) op("init", 32'h300 + 32'(4 * i), $urandom, 1'b1, 3'd2, rd, er);
    for (int k = 0; k < 60; k++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = IO_ADDR;
      else if (kind == 1) a = 32'h0002_0000 + 32'($urandom_range(0, 7));
      else                a = 32'h300 + 32'($urandom_range(0, 63));
      ioin = $urandom;
      op("rnd", a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rd, er);
    end

    // Back-to-back on the LATENCY=0 instance
    begin
      int acc[$];
      int rsps = 0;
      bit pend = 0;
      logic [31:0] lastW = 32'd0;
      int n;
      bus0.req_valid = 1'b1; bus0.req_addr = 32'h10; bus0.req_we = 1'b1; bus0.req_width = 3'd2;
      bus0.req_wdata = $urandom;
      for (int c = 0; c < 20; c++) begin
        if (pend) begin bus0.req_wdata = $urandom; pend = 0; end
        if (bus0.req_ready) begin acc.push_back(c); lastW = bus0.req_wdata; pend = 1; end
        if (bus0.rsp_valid) rsps++;
        @(negedge clk);
      end
      bus0.req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (bus0.rsp_valid) rsps++;
        @(negedge clk);
      end
      chk("b2b_count", 32'(acc.size()), 32'd7);
      for (int i = 1; i < acc.size(); i++) chk("b2b_gap", 32'(acc[i] - acc[i-1]), 32'd3);
      chk("b2b_rsps", 32'(rsps), 32'(acc.size()));
      n = 0;
      while (!bus0.req_ready && n < 10) begin @(negedge clk); n++; end
      bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 32'h10; bus0.req_width = 3'd2;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      n = 0;
      while (!bus0.rsp_valid && n < 10) begin @(negedge clk); n++; end
      chk("l0_lat", 32'(n), 32'd1);
      chk("l0_rdata", bus0.rsp_rdata, lastW);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
